decoder_seq: RTL and testbench

Parametrised, sequential successor to the 4-bit combinational instruction decoder. It owns the program counter, the instruction register and the carry flag, and runs a two-cycle FETCH/EXEC sequence. During EXEC it drives the datapath selector and register-load strobes. It adds conditional jump-on-carry, halt, NOP and run/single-step control, and sits between the program ROM and the A/B/OUT/ALU datapath.

---
 rtl/decoder_seq.sv | 167 ++++++++++++++++
 tb/tb_decoder_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// decoder_seq: two-cycle FETCH/EXEC instruction sequencer that owns the PC, IR and carry flag.
// All outputs are registered; EXEC-cycle controls are decoded while the instruction is fetched.
module decoder_seq #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_run,
    input  logic              in_step,
    input  logic [DATA_W+3:0] in_instr,
    input  logic              in_carry,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [1:0]        out_sel,
    output logic              out_ld_a,
    output logic              out_ld_b,
    output logic              out_ld_out,
    output logic              out_jump,
    output logic              out_carry,
    output logic              out_halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD_A   = 4'h0,
        OP_ADD_B   = 4'h1,
        OP_MOV_A_I = 4'h2,
        OP_MOV_B_I = 4'h3,
        OP_MOV_A_B = 4'h4,
        OP_MOV_B_A = 4'h5,
        OP_IN_A    = 4'h6,
        OP_IN_B    = 4'h7,
        OP_OUT_A   = 4'h8,
        OP_OUT_B   = 4'h9,
        OP_OUT_I   = 4'hA,
        OP_HLT     = 4'hB,
        OP_JC      = 4'hC,
        OP_NOP     = 4'hD,
        OP_JNC     = 4'hE,
        OP_JMP     = 4'hF
    } opcode_t;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_IN   = 2'd1;
    localparam logic [1:0] SEL_B    = 2'd2;
    localparam logic [1:0] SEL_ZERO = 2'd3;

    typedef struct packed {
        logic [1:0] sel;
        logic       ld_a;
        logic       ld_b;
        logic       ld_out;
        logic       jump;
    } ctrl_t;

    // Jump decisions use the flag as it stands at fetch; it cannot change before EXEC ends.
    function automatic ctrl_t decode_op(input opcode_t op, input logic flag);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD_A:   begin c.sel = SEL_A;    c.ld_a   = 1'b1; end
            OP_ADD_B:   begin c.sel = SEL_B;    c.ld_b   = 1'b1; end
            OP_MOV_A_I: begin c.sel = SEL_ZERO; c.ld_a   = 1'b1; end
            OP_MOV_B_I: begin c.sel = SEL_ZERO; c.ld_b   = 1'b1; end
            OP_MOV_A_B: begin c.sel = SEL_B;    c.ld_a   = 1'b1; end
            OP_MOV_B_A: begin c.sel = SEL_A;    c.ld_b   = 1'b1; end
            OP_IN_A:    begin c.sel = SEL_IN;   c.ld_a   = 1'b1; end
            OP_IN_B:    begin c.sel = SEL_IN;   c.ld_b   = 1'b1; end
            OP_OUT_A:   begin c.sel = SEL_A;    c.ld_out = 1'b1; end
            OP_OUT_B:   begin c.sel = SEL_B;    c.ld_out = 1'b1; end
            OP_OUT_I:   begin c.sel = SEL_ZERO; c.ld_out = 1'b1; end
            OP_JC:      begin c.sel = SEL_ZERO; c.jump   = flag; end
            OP_JNC:     begin c.sel = SEL_ZERO; c.jump   = ~flag; end
            OP_JMP:     begin c.sel = SEL_ZERO; c.jump   = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W+3:0]   ir_q, ir_d;
    logic                carry_q, carry_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic                halted_q, halted_d;

    opcode_t exec_op;
    ctrl_t   fetch_ctrl;
    logic    fetch_go;

    assign exec_op    = opcode_t'(ir_q[DATA_W+3:DATA_W]);
    assign fetch_ctrl = decode_op(opcode_t'(in_instr[DATA_W+3:DATA_W]), carry_q);
    assign fetch_go   = in_run | in_step;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        ctrl_d   = '0;
        halted_d = halted_q;

        case (state_q)
            ST_FETCH: begin
                if (fetch_go) begin
                    ir_d    = in_instr;
                    ctrl_d  = fetch_ctrl;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                carry_d = (exec_op == OP_ADD_A || exec_op == OP_ADD_B) ? in_carry : 1'b0;
                if (exec_op == OP_HLT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = ctrl_q.jump ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d  = ST_FETCH;
                halted_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (in_rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            ctrl_q   <= ctrl_d;
            halted_q <= halted_d;
        end
    end

    assign out_pc     = pc_q;
    assign out_imm    = ir_q[DATA_W-1:0];
    assign out_sel    = ctrl_q.sel;
    assign out_ld_a   = ctrl_q.ld_a;
    assign out_ld_b   = ctrl_q.ld_b;
    assign out_ld_out = ctrl_q.ld_out;
    assign out_jump   = ctrl_q.jump;
    assign out_carry  = carry_q;
    assign out_halted = halted_q;

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed and random program runs against an instruction-level reference model.
// A second, wider instance covers the DATA_W=8 / ADDR_W=6 jump and reset cases.
module tb_decoder_seq;

    logic in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    logic       in_rst, in_run, in_step, in_carry;
    logic [7:0] in_instr;
    logic [3:0] out_pc, out_imm;
    logic [1:0] out_sel;
    logic       out_ld_a, out_ld_b, out_ld_out, out_jump, out_carry, out_halted;
    logic [7:0] rom [16];

    assign in_instr = rom[out_pc];

    decoder_seq #(.DATA_W(4), .ADDR_W(4)) u_dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_run    (in_run),
        .in_step   (in_step),
        .in_instr  (in_instr),
        .in_carry  (in_carry),
        .out_pc    (out_pc),
        .out_imm   (out_imm),
        .out_sel   (out_sel),
        .out_ld_a  (out_ld_a),
        .out_ld_b  (out_ld_b),
        .out_ld_out(out_ld_out),
        .out_jump  (out_jump),
        .out_carry (out_carry),
        .out_halted(out_halted)
    );

    logic        run2, step2, carry2;
    logic [11:0] instr2;
    logic [5:0]  pc2;
    logic [7:0]  imm2;
    logic [1:0]  sel2;
    logic        ld_a2, ld_b2, ld_out2, jump2, flag2, halted2;
    logic [11:0] rom2 [64];

    assign instr2 = rom2[pc2];

    decoder_seq #(.DATA_W(8), .ADDR_W(6)) u_dut_wide (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_run    (run2),
        .in_step   (step2),
        .in_instr  (instr2),
        .in_carry  (carry2),
        .out_pc    (pc2),
        .out_imm   (imm2),
        .out_sel   (sel2),
        .out_ld_a  (ld_a2),
        .out_ld_b  (ld_b2),
        .out_ld_out(ld_out2),
        .out_jump  (jump2),
        .out_carry (flag2),
        .out_halted(halted2)
    );

    int total = 0;
    int bad   = 0;

    // Architectural model: program counter, carry flag and halt status only.
    int m_pc, m_carry, m_halted;
    // ALU source per opcode; -1 where the opcode loads nothing and the source is irrelevant.
    int sel_tab [16] = '{0, 2, 3, 3, 2, 0, 1, 1, 0, 2, 3, -1, 3, -1, 3, 3};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_pc", out_pc, 0);
        check("rst_imm", out_imm, 0);
        check("rst_ctrl", {out_sel, out_ld_a, out_ld_b, out_ld_out, out_jump}, 0);
        check("rst_flag", out_carry, 0);
        check("rst_halted", out_halted, 0);
        check("rst_wide_pc", pc2, 0);
        check("rst_wide_imm", imm2, 0);
        check("rst_wide_ctrl", {sel2, ld_a2, ld_b2, ld_out2, jump2, flag2, halted2}, 0);
    endtask

    task automatic do_reset();
        in_rst  = 1'b1;
        in_run  = 1'b0;
        in_step = 1'b0;
        run2    = 1'b0;
        step2   = 1'b0;
        tick();
        in_rst   = 1'b0;
        m_pc     = 0;
        m_carry  = 0;
        m_halted = 0;
        check_reset_state();
    endtask

    // Runs the instruction at m_pc: one FETCH cycle, one EXEC cycle, then checks the outcome.
    task automatic exec_one(input bit use_step, input bit cin, input bit run_in_exec);
        int op, imm;
        bit e_a, e_b, e_o, e_jump;
        op  = int'(rom[m_pc][7:4]);
        imm = int'(rom[m_pc][3:0]);
        check("fetch_pc", out_pc, m_pc);
        check("fetch_ctrl", {out_sel, out_ld_a, out_ld_b, out_ld_out, out_jump}, 0);
        check("fetch_halted", out_halted, 0);
        in_run  = !use_step;
        in_step = use_step;
        tick();
        in_run   = run_in_exec;
        in_step  = 1'b0;
        in_carry = cin;
        e_a    = (op < 8) && (op % 2 == 0);
        e_b    = (op < 8) && (op % 2 == 1);
        e_o    = (op >= 8) && (op <= 10);
        e_jump = (op == 15) || (op == 12 && m_carry == 1) || (op == 14 && m_carry == 0);
        check("exec_imm", out_imm, imm);
        if (sel_tab[op] >= 0) check("exec_sel", out_sel, sel_tab[op]);
        check("exec_loads", {out_ld_a, out_ld_b, out_ld_out}, {e_a, e_b, e_o});
        check("exec_jump", out_jump, e_jump);
        check("exec_flag", out_carry, m_carry);
        tick();
        in_run   = 1'b0;
        in_carry = 1'($urandom);
        if (op == 11) m_halted = 1;
        else          m_pc = e_jump ? imm % 16 : (m_pc + 1) % 16;
        m_carry = (op <= 1) ? int'(cin) : 0;
        check("post_pc", out_pc, m_pc);
        check("post_flag", out_carry, m_carry);
        check("post_halted", out_halted, m_halted);
        check("post_ctrl", {out_ld_a, out_ld_b, out_ld_out, out_jump}, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_pc", out_pc, m_pc);
            check("idle_ctrl", {out_sel, out_ld_a, out_ld_b, out_ld_out, out_jump}, 0);
        end
    endtask

    initial begin
        in_rst   = 1'b1;
        in_run   = 1'b0;
        in_step  = 1'b0;
        in_carry = 1'b0;
        run2     = 1'b0;
        step2    = 1'b0;
        carry2   = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hD0;
        for (int i = 0; i < 64; i++) rom2[i] = 12'hD00;

        // Basic program: moves, carry set/clear, taken and untaken conditional jumps.
        do_reset();
        rom[0]  = 8'h25;  // MOV A,5
        rom[1]  = 8'h03;  // ADD A,3
        rom[2]  = 8'hD0;  // NOP
        rom[3]  = 8'h01;  // ADD A,1
        rom[4]  = 8'hE7;  // JNC 7
        rom[5]  = 8'h12;  // ADD B,2
        rom[6]  = 8'hC9;  // JC 9
        rom[7]  = 8'hFF;  // JMP 15
        rom[9]  = 8'hFF;  // JMP 15
        rom[15] = 8'hF3;  // JMP 3
        idle(2);
        exec_one(0, 0, 0);
        check("mov_a_imm", out_imm, 5);
        exec_one(0, 1, 0);
        check("add_sets_flag", out_carry, 1);
        exec_one(0, 0, 1);
        check("nop_clears_flag", out_carry, 0);
        exec_one(0, 1, 0);
        exec_one(0, 0, 0);
        check("jnc_untaken_pc", out_pc, 5);
        exec_one(0, 1, 1);
        exec_one(0, 0, 0);
        check("jc_taken_pc", out_pc, 9);
        exec_one(0, 0, 0);
        exec_one(0, 0, 1);
        check("jmp_from_15", out_pc, 3);
        rom[15] = 8'hD0;
        exec_one(0, 0, 0);
        exec_one(0, 0, 0);
        check("jnc_taken_pc", out_pc, 7);
        exec_one(0, 1, 0);
        exec_one(0, 0, 0);
        check("pc_wrap", out_pc, 0);

        // HLT at pc 4 must freeze everything until reset.
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'hD0;
        rom[4] = 8'hB6;
        for (int i = 0; i < 5; i++) exec_one(0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            in_run  = 1'b1;
            in_step = (i % 2 == 0);
            tick();
            check("halt_pc", out_pc, 4);
            check("halt_flag", out_halted, 1);
            check("halt_ctrl", {out_ld_a, out_ld_b, out_ld_out, out_jump, out_carry}, 0);
        end
        do_reset();

        // Single-step pulses: one instruction per pulse, nothing in between.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 5))
                0: rom[i] = {4'h0, 4'($urandom)};
                1: rom[i] = {4'h1, 4'($urandom)};
                2: rom[i] = {4'h6, 4'($urandom)};
                3: rom[i] = {4'h9, 4'($urandom)};
                4: rom[i] = {4'hA, 4'($urandom)};
                default: rom[i] = {4'h5, 4'($urandom)};
            endcase
        end
        for (int i = 0; i < 6; i++) begin
            exec_one(1, 1'($urandom), 0);
            idle(3);
        end

        // Reset during EXEC of ADD A at pc 2: no pc or flag update survives.
        do_reset();
        rom[0] = 8'hD0;
        rom[1] = 8'hD0;
        rom[2] = 8'h07;
        exec_one(0, 0, 0);
        exec_one(0, 0, 0);
        in_run = 1'b1;
        tick();
        in_run = 1'b0;
        check("mid_exec_ld_a", out_ld_a, 1);
        in_carry = 1'b1;
        in_rst   = 1'b1;
        tick();
        in_rst   = 1'b0;
        m_pc     = 0;
        m_carry  = 0;
        check_reset_state();
        idle(2);
        exec_one(0, 0, 0);

        // Random programs, random run/step modes, carry inputs and idle gaps.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            if (n % 30 == 0) for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            if (m_halted == 1) begin
                idle(2);
                check("rand_halted", out_halted, 1);
                do_reset();
            end
            exec_one(1'($urandom), 1'($urandom), 1'($urandom));
            if (m_halted == 0) idle($urandom_range(0, 2));
        end

        // Wide instance: JMP 0x3F, wrap from 63, reset during EXEC of ADD A.
        do_reset();
        rom2[0]  = 12'hF3F;
        rom2[63] = 12'hD00;
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        check("wide_jmp_strobe", jump2, 1);
        check("wide_jmp_sel", sel2, 3);
        check("wide_jmp_imm", imm2, 8'h3F);
        tick();
        check("wide_jmp_pc", pc2, 63);
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        check("wide_nop_ctrl", {ld_a2, ld_b2, ld_out2, jump2}, 0);
        tick();
        check("wide_wrap_pc", pc2, 0);
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        tick();
        check("wide_jmp_pc2", pc2, 63);
        rom2[63] = 12'h0A5;
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        check("wide_add_ld_a", ld_a2, 1);
        check("wide_add_imm", imm2, 8'hA5);
        check("wide_add_sel", sel2, 0);
        carry2 = 1'b1;
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        m_pc    = 0;
        m_carry = 0;
        check_reset_state();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
